// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for uart_rx_fifo: upstream UART byte handshake plus the consumer pop/status side.
// Upstream byte handshake: RX_DATA_VALID is held high with a stable RX_DATA until RX_DATA_READ pulses for one cycle; the byte is taken on the edge that ends that cycle.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  logic [7:0]               RX_DATA;
  logic                     RX_DATA_VALID;
  logic                     RX_DATA_READ;
  logic                     RD_EN;
  logic [7:0]               RD_DATA;
  logic                     EMPTY;
  logic                     FULL;
  logic [$clog2(DEPTH):0]   COUNT;
  logic                     OVERRUN;
  logic                     OVERRUN_CLR;
  logic [0:0]               intake_state;

  modport master (
    output RX_DATA, RX_DATA_VALID, RD_EN, OVERRUN_CLR,
    input  RX_DATA_READ, RD_DATA, EMPTY, FULL, COUNT, OVERRUN, intake_state
  );

  modport slave (
    input  RX_DATA, RX_DATA_VALID, RD_EN, OVERRUN_CLR,
    output RX_DATA_READ, RD_DATA, EMPTY, FULL, COUNT, OVERRUN, intake_state
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: one-cycle ack intake, show-ahead read port, sticky overrun flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input logic ACLK,
  input logic RESETN,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]    state;
  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          ack;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  logic          empty;

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  always_comb begin
    empty = (count == '0);
    full  = (count == CNT_FULL);
    ack   = (state == ST_WAIT) && bus.RX_DATA_VALID;
    pop   = bus.RD_EN && !empty;
    push  = ack && (!full || pop);
    drop  = ack && full && !pop;
  end

  // HOLD spaces acks apart so an upstream that is slow to drop VALID is not double-read.
  always_ff @(posedge ACLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_WAIT;
    end else begin
      case (state)
        ST_WAIT: if (bus.RX_DATA_VALID) state <= ST_HOLD;
        default: state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= bus.RX_DATA;
  end

  // Setting wins over a coincident clear so a drop is never lost.
  always_ff @(posedge ACLK or negedge RESETN) begin
    if (!RESETN)              overrun <= 1'b0;
    else if (drop)            overrun <= 1'b1;
    else if (bus.OVERRUN_CLR) overrun <= 1'b0;
  end

  assign bus.RX_DATA_READ = ack;
  assign bus.RD_DATA      = empty ? 8'h00 : mem[rd_ptr];
  assign bus.EMPTY        = empty;
  assign bus.FULL         = full;
  assign bus.COUNT        = count;
  assign bus.OVERRUN      = overrun;
  assign bus.intake_state = state;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written corner sequences and random traffic against a queue model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic ACLK   = 1'b0;
  logic RESETN = 1'b0;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .ACLK   (ACLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: byte queue, sticky flag, and whether the previous cycle was acked
  logic [7:0] exp_q[$];
  logic       exp_ov;
  logic       prev_ack;

  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic          rd;
    logic          clr;
    logic          e_ack;
    logic          e_empty;
    logic [CW-1:0] e_count;
    logic [7:0]    e_data;
    logic          e_ov;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ov   = 1'b0;
    prev_ack = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check({tag, "_empty"},   bus.EMPTY,   exp_q.size() == 0);
    check({tag, "_full"},    bus.FULL,    exp_q.size() == DEPTH);
    check({tag, "_count"},   bus.COUNT,   exp_q.size());
    check({tag, "_rd_data"}, bus.RD_DATA, head);
    check({tag, "_overrun"}, bus.OVERRUN, exp_ov);
  endtask

  // driver: one clock cycle, entered and left 1ns after a rising edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic rd, input logic clr,
                       output logic ack_seen);
    logic exp_ack, do_pop, do_push, do_drop, is_full;
    bus.RX_DATA_VALID = v;
    bus.RX_DATA       = d;
    bus.RD_EN         = rd;
    bus.OVERRUN_CLR   = clr;
    #2;
    exp_ack  = v && !prev_ack;
    ack_seen = bus.RX_DATA_READ;
    check("rx_data_read", ack_seen, exp_ack);
    check_outputs("pre_edge");
    is_full = (exp_q.size() == DEPTH);
    do_pop  = rd && (exp_q.size() != 0);
    do_push = exp_ack && (!is_full || do_pop);
    do_drop = exp_ack && is_full && !do_pop;
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    if (do_drop)   exp_ov = 1'b1;
    else if (clr)  exp_ov = 1'b0;
    prev_ack = exp_ack;
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic a;
    cycle(1'b1, d, 1'b0, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
  endtask

  task automatic pop_expect(input logic [7:0] e);
    logic a;
    check("drain_order", bus.RD_DATA, e);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
  endtask

  initial begin
    logic a;
    int   thr;
    bus.RX_DATA       = 8'h00;
    bus.RX_DATA_VALID = 1'b0;
    bus.RD_EN         = 1'b0;
    bus.OVERRUN_CLR   = 1'b0;
    model_reset();

    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, CW'(1), 8'hA5, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, CW'(1), 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, CW'(0), 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, CW'(1), 8'h22, 1'b0};
    vecs[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, CW'(1), 8'h22, 1'b0};
    vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, CW'(2), 8'h22, 1'b0};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, CW'(2), 8'h22, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, CW'(1), 8'h22, 1'b0};
    vecs[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, CW'(1), 8'h44, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, CW'(0), 8'h00, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, CW'(0), 8'h00, 1'b0};
    vecs[11] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, CW'(1), 8'h5A, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, CW'(0), 8'h00, 1'b0};

    // reset state
    #12;
    check("reset_empty",   bus.EMPTY,   1'b1);
    check("reset_full",    bus.FULL,    1'b0);
    check("reset_count",   bus.COUNT,   0);
    check("reset_rd_data", bus.RD_DATA, 8'h00);
    check("reset_overrun", bus.OVERRUN, 1'b0);
    bus.RX_DATA_VALID = 1'b1;
    #1;
    check("reset_ack_follows_valid", bus.RX_DATA_READ, 1'b1);
    bus.RX_DATA_VALID = 1'b0;
    RESETN = 1'b1;
    @(posedge ACLK);
    #1;

    // directed vector table: single byte, held-VALID handshake, empty-pop corner cases
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].clr, a);
      check($sformatf("vec%0d_ack", i),     a,           vecs[i].e_ack);
      check($sformatf("vec%0d_empty", i),   bus.EMPTY,   vecs[i].e_empty);
      check($sformatf("vec%0d_count", i),   bus.COUNT,   vecs[i].e_count);
      check($sformatf("vec%0d_rd_data", i), bus.RD_DATA, vecs[i].e_data);
      check($sformatf("vec%0d_overrun", i), bus.OVERRUN, vecs[i].e_ov);
    end

    // fill, overrun on a dropped byte, ordered drain
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("fill_full",  bus.FULL,  1'b1);
    check("fill_count", bus.COUNT, DEPTH);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, a);
    check("drop_acked",   a,           1'b1);
    check("drop_overrun", bus.OVERRUN, 1'b1);
    check("drop_count",   bus.COUNT,   DEPTH);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
    for (int i = 0; i < DEPTH; i++) pop_expect(8'(i));
    check("drain_empty", bus.EMPTY, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
    check("clear_overrun", bus.OVERRUN, 1'b0);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
    cycle(1'b1, 8'h55, 1'b1, 1'b0, a);
    check("pushpop_count",   bus.COUNT,   DEPTH);
    check("pushpop_overrun", bus.OVERRUN, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
    for (int i = 1; i < DEPTH; i++) pop_expect(8'h80 + 8'(i));
    pop_expect(8'h55);
    check("pushpop_empty", bus.EMPTY, 1'b1);

    // clear coincident with a drop: set wins, then clear takes effect
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, a);
    check("set_beats_clear", bus.OVERRUN, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
    check("clear_after_set", bus.OVERRUN, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop_expect(8'h10 + 8'(i));

    // interleaved push/pop across pointer wrap
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, a);
      check("wrap_head", bus.RD_DATA, 8'hC0 + 8'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    end

    // random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 800; i++) begin
      thr = ((i / 100) % 2 == 0) ? 1 : 3;
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) < thr,
            $urandom_range(0, 15) == 0, a);
    end
    while (exp_q.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, a);

    // asynchronous reset mid-stream while the intake is in HOLD
    for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
    cycle(1'b1, 8'h64, 1'b0, 1'b0, a);
    check("pre_reset_count", bus.COUNT, 5);
    #2;
    RESETN = 1'b0;
    bus.RX_DATA_VALID = 1'b1;
    #1;
    check("async_reset_empty",   bus.EMPTY,        1'b1);
    check("async_reset_full",    bus.FULL,         1'b0);
    check("async_reset_count",   bus.COUNT,        0);
    check("async_reset_rd_data", bus.RD_DATA,      8'h00);
    check("async_reset_overrun", bus.OVERRUN,      1'b0);
    check("async_reset_ack",     bus.RX_DATA_READ, 1'b1);
    bus.RX_DATA_VALID = 1'b0;
    #1;
    RESETN = 1'b1;
    model_reset();
    @(posedge ACLK);
    #1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, a);
    check("post_reset_ack",     a,           1'b1);
    check("post_reset_rd_data", bus.RD_DATA, 8'h3C);
    check("post_reset_count",   bus.COUNT,   1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
    pop_expect(8'h3C);
    check("post_reset_empty", bus.EMPTY, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in bytes; power of two, >= 2.
REQ-002 ACLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESETN  input  1  reset, asynchronous assertion, active-low.
REQ-004 RX_DATA  input  8  received byte from upstream UART receiver.
REQ-005 RX_DATA_VALID  input  1  upstream byte available; held high until acknowledged.
REQ-006 RX_DATA_READ  output  1  one-cycle acknowledge to upstream receiver.
REQ-007 RD_EN  input  1  consumer pop request.
REQ-008 RD_DATA  output  8  head-of-FIFO byte, show-ahead.
REQ-009 EMPTY  output  1  FIFO holds zero bytes.
REQ-010 FULL  output  1  FIFO holds DEPTH bytes.
REQ-011 COUNT  output  $clog2(DEPTH)+1  bytes currently stored.
REQ-012 OVERRUN  output  1  sticky flag: a byte was dropped because FIFO was full.
REQ-013 OVERRUN_CLR  input  1  clears OVERRUN.

Function
REQ-014 Storage: DEPTH x 8 array, write pointer and read pointer $clog2(DEPTH) bits each, wrapping modulo DEPTH; COUNT tracked separately.
REQ-015 Intake FSM, two states: WAIT, HOLD.
REQ-016 WAIT: if RX_DATA_VALID=1, RX_DATA_READ=1 combinationally in that cycle; FSM moves to HOLD; else stays in WAIT and RX_DATA_READ=0.
REQ-017 HOLD: RX_DATA_READ=0; RX_DATA_VALID ignored; FSM returns to WAIT next cycle (guarantees ack is never asserted two consecutive cycles while upstream deasserts VALID).
REQ-018 Push: occurs on the edge ending a WAIT cycle with RX_DATA_VALID=1, provided FULL=0 or a pop is accepted that same cycle; RX_DATA written at write pointer, write pointer +1.
REQ-019 Drop: WAIT with RX_DATA_VALID=1, FULL=1 and no pop -> byte still acknowledged, not stored, OVERRUN set on that edge.
REQ-020 Pop: accepted when RD_EN=1 and EMPTY=0; read pointer +1 on the edge; RD_EN while EMPTY=1 is ignored, no state change.
REQ-021 COUNT: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or neither; never exceeds DEPTH, never below 0.
REQ-022 EMPTY = (COUNT==0), FULL = (COUNT==DEPTH), both combinational from COUNT.
REQ-023 RD_DATA = array[read pointer] when EMPTY=0; 8'h00 when EMPTY=1.
REQ-024 Latency: byte pushed on edge t is visible on RD_DATA with EMPTY=0 immediately after edge t; push into empty FIFO with simultaneous RD_EN does not pop (EMPTY=1 that cycle).
REQ-025 Full with simultaneous pop and valid intake: both occur, COUNT stays DEPTH, no overrun.
REQ-026 OVERRUN: cleared on edge when OVERRUN_CLR=1; if set and clear coincide, set wins.
REQ-027 Ordering strictly first-in first-out across pointer wrap-around.

Reset
REQ-028 RESETN=0 asynchronously forces: FSM=WAIT, pointers=0, COUNT=0, OVERRUN=0; hence EMPTY=1, FULL=0, RD_DATA=8'h00, RX_DATA_READ follows RX_DATA_VALID.
REQ-029 Array contents need not be reset; all stored bytes are discarded by reset.
REQ-030 Reset mid-operation (including during HOLD) returns to REQ-028 state; first valid byte after release is accepted normally.

Verification
REQ-031 Single byte: VALID=1 with 8'hA5 for 1 cycle -> RX_DATA_READ=1 that cycle, next cycle EMPTY=0, RD_DATA=8'hA5, COUNT=1; RD_EN=1 -> EMPTY=1, RD_DATA=8'h00.
REQ-032 Handshake: VALID held high 4 cycles -> RX_DATA_READ pattern 1,0,1,0 and two pushes (upstream-hold misuse still yields no back-to-back acks).
REQ-033 Fill/overrun: push 16 bytes 8'h00..8'h0F (DEPTH=16) -> FULL=1, COUNT=16; push 8'hFF -> acked, dropped, OVERRUN=1; drain returns 8'h00..8'h0F in order.
REQ-034 Full with push+pop same cycle: FULL, RD_EN=1, push 8'h55 -> COUNT=16, OVERRUN=0, 8'h55 read last.
REQ-035 Wrap and clear: 40 interleaved push/pop bytes -> FIFO order preserved; OVERRUN_CLR=1 coincident with drop -> OVERRUN stays 1, next cycle clear -> 0.
REQ-036 Reset mid-stream: COUNT=5, assert RESETN=0 between edges -> outputs change immediately to reset values; after release byte 8'h3C stored and read correctly.
